// File: rtl/cond_logic.sv
// cond_logic: architectural NZCV flags register, condition-field evaluation,
// condition-gated datapath write strobes and executed/squashed counters.
// Flags are written only by instructions whose own condition passed, and each
// instruction is judged against the flags as they stood before its own edge.
module cond_logic #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             InstrValid,
   input  logic [3:0]       Cond,
   input  logic [3:0]       ALUFlags,
   input  logic [1:0]       FlagW,
   input  logic             PCS,
   input  logic             RegW,
   input  logic             MemW,
   input  logic             NoWrite,
   input  logic             CountClr,
   output logic             PCSrc,
   output logic             RegWrite,
   output logic             MemWrite,
   output logic             CondEx,
   output logic [3:0]       Flags,
   output logic [CNT_W-1:0] ExecCount,
   output logic [CNT_W-1:0] SquashCount
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // Evaluate a 4-bit condition code against an NZCV vector ([3]=N .. [0]=V).
   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
      logic n_s;
      logic z_s;
      logic c_s;
      logic v_s;
      logic res_s;
      n_s = nzcv[3];
      z_s = nzcv[2];
      c_s = nzcv[1];
      v_s = nzcv[0];
      case (cond)
         4'b0000: res_s = z_s;                        // EQ
         4'b0001: res_s = ~z_s;                       // NE
         4'b0010: res_s = c_s;                        // CS
         4'b0011: res_s = ~c_s;                       // CC
         4'b0100: res_s = n_s;                        // MI
         4'b0101: res_s = ~n_s;                       // PL
         4'b0110: res_s = v_s;                        // VS
         4'b0111: res_s = ~v_s;                       // VC
         4'b1000: res_s = c_s & ~z_s;                 // HI
         4'b1001: res_s = ~c_s | z_s;                 // LS
         4'b1010: res_s = ~(n_s ^ v_s);               // GE
         4'b1011: res_s = n_s ^ v_s;                  // LT
         4'b1100: res_s = ~z_s & ~(n_s ^ v_s);        // GT
         4'b1101: res_s = z_s | (n_s ^ v_s);          // LE
         4'b1110: res_s = 1'b1;                       // AL
         default: res_s = 1'b1;                       // unconditional
      endcase
      return res_s;
   endfunction

   logic [3:0]       flags_r;
   logic [CNT_W-1:0] exec_cnt_r;
   logic [CNT_W-1:0] squash_cnt_r;
   logic             cond_ex_s;
   logic             go_s;

   // Condition result from the stored flags and the gated write strobes.
   always_comb begin
      cond_ex_s = cond_eval(Cond, flags_r);
      go_s      = InstrValid & cond_ex_s;
      PCSrc     = PCS & go_s;
      RegWrite  = RegW & go_s & ~NoWrite;
      MemWrite  = MemW & go_s;
   end

   assign CondEx      = cond_ex_s;
   assign Flags       = flags_r;
   assign ExecCount   = exec_cnt_r;
   assign SquashCount = squash_cnt_r;

   // Flags register: N,Z and C,V fields are written independently, and only
   // by an executing instruction, so ALU bits that were not requested (which
   // may be X for logic ops) never enter the register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flags_r <= 4'b0000;
      end else begin
         if (go_s && FlagW[1]) begin
            flags_r[3:2] <= ALUFlags[3:2];
         end
         if (go_s && FlagW[0]) begin
            flags_r[1:0] <= ALUFlags[1:0];
         end
      end
   end

   // Executed / squashed counters; clear wins over increment, wrap on overflow.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         exec_cnt_r   <= CNT_ZERO;
         squash_cnt_r <= CNT_ZERO;
      end else if (CountClr) begin
         exec_cnt_r   <= CNT_ZERO;
         squash_cnt_r <= CNT_ZERO;
      end else if (InstrValid) begin
         if (cond_ex_s) begin
            exec_cnt_r <= exec_cnt_r + CNT_ONE;
         end else begin
            squash_cnt_r <= squash_cnt_r + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_cond_logic.sv
// Self-checking bench for cond_logic: a per-instruction reference model that
// tracks N,Z,C,V and the two counts as plain values, a compare process that
// checks every output on each falling edge, and directed hand-computed checks.
module tb_cond_logic;

   localparam int CW = 4;

   logic          clk;
   logic          reset;
   logic          InstrValid;
   logic [3:0]    Cond;
   logic [3:0]    ALUFlags;
   logic [1:0]    FlagW;
   logic          PCS;
   logic          RegW;
   logic          MemW;
   logic          NoWrite;
   logic          CountClr;
   logic          PCSrc;
   logic          RegWrite;
   logic          MemWrite;
   logic          CondEx;
   logic [3:0]    Flags;
   logic [CW-1:0] ExecCount;
   logic [CW-1:0] SquashCount;

   int total = 0;
   int bad   = 0;
   logic chk_en = 1'b0;

   // reference model state
   logic m_n, m_z, m_c, m_v;
   int   m_exec, m_sq;

   cond_logic #(.CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .InstrValid(InstrValid), .Cond(Cond),
      .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW), .MemW(MemW),
      .NoWrite(NoWrite), .CountClr(CountClr), .PCSrc(PCSrc), .RegWrite(RegWrite),
      .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags), .ExecCount(ExecCount),
      .SquashCount(SquashCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Condition rule: pick the base test by cond[3:1]; odd codes invert it,
   // except the always-true pair 111x.
   function automatic bit mcond(input logic [3:0] c, input bit n, input bit z, input bit cy, input bit v);
      bit r;
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cy;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cy && !z;
         3'd5: r = (n == v);
         3'd6: r = !z && (n == v);
         default: r = 1'b1;
      endcase
      if (c[0] && c[3:1] != 3'd7) r = !r;
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one instruction per rising edge.
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_n <= 1'b0; m_z <= 1'b0; m_c <= 1'b0; m_v <= 1'b0;
         m_exec <= 0; m_sq <= 0;
      end else begin
         if (InstrValid && mcond(Cond, m_n, m_z, m_c, m_v)) begin
            if (FlagW[1]) begin m_n <= ALUFlags[3]; m_z <= ALUFlags[2]; end
            if (FlagW[0]) begin m_c <= ALUFlags[1]; m_v <= ALUFlags[0]; end
         end
         if (CountClr) begin
            m_exec <= 0; m_sq <= 0;
         end else if (InstrValid) begin
            if (mcond(Cond, m_n, m_z, m_c, m_v)) m_exec <= m_exec + 1;
            else m_sq <= m_sq + 1;
         end
      end
   end

   // Compare every output against the model away from the active edge.
   always @(negedge clk) begin
      if (chk_en && reset === 1'b1) begin
         chk("m_CondEx", 32'(CondEx), 32'(mcond(Cond, m_n, m_z, m_c, m_v)));
         chk("m_PCSrc", 32'(PCSrc), 32'(PCS && InstrValid && mcond(Cond, m_n, m_z, m_c, m_v)));
         chk("m_RegWrite", 32'(RegWrite), 32'(RegW && !NoWrite && InstrValid && mcond(Cond, m_n, m_z, m_c, m_v)));
         chk("m_MemWrite", 32'(MemWrite), 32'(MemW && InstrValid && mcond(Cond, m_n, m_z, m_c, m_v)));
         chk("m_Flags", 32'(Flags), 32'({m_n, m_z, m_c, m_v}));
         chk("m_ExecCount", 32'(ExecCount), 32'(m_exec % (1 << CW)));
         chk("m_SquashCount", 32'(SquashCount), 32'(m_sq % (1 << CW)));
      end
   end

   task automatic drv(input logic v, input logic [3:0] c, input logic [3:0] a, input logic [1:0] fw,
                      input logic p, input logic r, input logic m, input logic nw, input logic clr);
      InstrValid = v; Cond = c; ALUFlags = a; FlagW = fw;
      PCS = p; RegW = r; MemW = m; NoWrite = nw; CountClr = clr;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b0;
      drv(1'b0, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      chk("rst_Flags", 32'(Flags), 32'h0);
      chk("rst_Exec", 32'(ExecCount), 32'h0);
      chk("rst_Squash", 32'(SquashCount), 32'h0);
      chk("rst_CondEx_EQ", 32'(CondEx), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      chk_en = 1'b1;
      tick();

      // EQ fails on cleared flags, AL passes
      drv(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("eq_CondEx", 32'(CondEx), 32'h0);
      chk("eq_RegWrite", 32'(RegWrite), 32'h0);
      tick();
      chk("eq_Squash", 32'(SquashCount), 32'h1);
      drv(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      #1;
      chk("al_RegWrite", 32'(RegWrite), 32'h1);
      tick();
      chk("al_Exec", 32'(ExecCount), 32'h1);

      // flag update latency: same cycle sees old flags
      drv(1'b1, 4'b0000, 4'b0100, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("old_flags_EQ", 32'(CondEx), 32'h0);
      Cond = 4'b1110;
      tick();
      chk("upd_Flags", 32'(Flags), 32'h4);
      drv(1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("new_flags_EQ", 32'(CondEx), 32'h1);
      tick();

      // partial writes, X on unrequested bits
      drv(1'b1, 4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("part_Flags0", 32'(Flags), 32'ha);
      drv(1'b1, 4'b1110, 4'b01xx, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("part_Flags1", 32'(Flags), 32'h6);
      chk("part_noX", 32'($isunknown(Flags)), 32'h0);
      drv(1'b1, 4'b1110, 4'b0001, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("part_Flags2", 32'(Flags), 32'h5);

      // signed conditions, N=1 V=0 Z=0
      drv(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1; chk("nv10_GE", 32'(CondEx), 32'h0);
      Cond = 4'b1011;
      #1; chk("nv10_LT", 32'(CondEx), 32'h1);
      tick();
      Cond = 4'b1100;
      #1; chk("nv10_GT", 32'(CondEx), 32'h0);
      Cond = 4'b1101;
      #1; chk("nv10_LE", 32'(CondEx), 32'h1);
      tick();
      // N=1 V=1 Z=0
      drv(1'b1, 4'b1110, 4'b1001, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b0, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1; chk("nv11_GE", 32'(CondEx), 32'h1);
      Cond = 4'b1100;
      #1; chk("nv11_GT", 32'(CondEx), 32'h1);
      tick();
      // C=1 Z=0
      drv(1'b1, 4'b1110, 4'b0010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b0, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1; chk("c1_HI", 32'(CondEx), 32'h1);
      Cond = 4'b1001;
      #1; chk("c1_LS", 32'(CondEx), 32'h0);
      tick();

      // squashed flag write and strobes
      drv(1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drv(1'b1, 4'b0000, 4'b1111, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      chk("sq_MemWrite", 32'(MemWrite), 32'h0);
      chk("sq_PCSrc", 32'(PCSrc), 32'h0);
      tick();
      chk("sq_Flags", 32'(Flags), 32'h0);
      drv(1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
      #1;
      chk("nw_RegWrite", 32'(RegWrite), 32'h0);
      tick();
      chk("nw_Flags", 32'(Flags), 32'h4);

      // counters: clear, wrap at 2^CW, clear beats increment
      drv(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("clr_Exec", 32'(ExecCount), 32'h0);
      chk("clr_Squash", 32'(SquashCount), 32'h0);
      drv(1'b1, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 15; i++) tick();
      chk("cnt_Exec15", 32'(ExecCount), 32'hf);
      tick();
      chk("cnt_wrap", 32'(ExecCount), 32'h0);
      tick();
      tick();
      chk("cnt_Exec2", 32'(ExecCount), 32'h2);
      CountClr = 1'b1;
      tick();
      chk("clr_prio", 32'(ExecCount), 32'h0);

      // directed sweep over all conditions with varied flags and strobes
      for (int i = 0; i < 64; i++) begin
         drv(i % 5 != 4, 4'(i % 16), 4'((i * 7 + 3) % 16), 2'(i % 4),
             1'(i >> 1), 1'(i >> 2), 1'(i >> 3), 1'(i >> 4), 1'(i == 40));
         tick();
      end

      // async reset mid-stream
      drv(1'b1, 4'b1110, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      #2;
      reset = 1'b0;
      #1;
      chk("arst_Flags", 32'(Flags), 32'h0);
      chk("arst_Exec", 32'(ExecCount), 32'h0);
      chk("arst_Squash", 32'(SquashCount), 32'h0);
      @(negedge clk);
      reset = 1'b1;
      drv(1'b1, 4'b1110, 4'b1000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      chk("post_Flags", 32'(Flags), 32'h8);
      chk("post_Exec", 32'(ExecCount), 32'h1);
      drv(1'b0, 4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
